sync_fifo: RTL and testbench
============================

Name: sync_fifo

Overview:
Parametrised single-clock FIFO, successor to the basic 4x4 FIFO used in the examples.
- Adds:
  - true full/empty via an occupancy counter
  - programmable almost-full/almost-empty thresholds
  - live fill count
  - registered overflow/underflow error pulses
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between a producer and consumer in the same clock domain; the memory array is a separate sub-module.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 16, number of entries; power of two, >=2.
- FWFT, 0, read mode: 0 = standard (data_out registered, valid 1 cycle after read); 1 = first-word-fall-through (head word always on data_out while not empty).
- AF_THRESH, DEPTH-2, almost_full asserted when count >= AF_THRESH.
- AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- data_in  in  WIDTH  write data.
- write  in  1  write request.
- read  in  1  read request.
- data_out  out  WIDTH  read data.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.
- fifo_full  out  1  count == DEPTH.
- fifo_empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- overflow  out  1  one-cycle pulse: write rejected in previous cycle.
- underflow  out  1  one-cycle pulse: read rejected in previous cycle.

Behaviour:
- Reset (async, rst=1):
  - write_ptr = read_ptr = 0, count = 0, data_out = 0.
  - fifo_empty = 1, almost_empty = 1, fifo_full = 0, almost_full = 0, overflow = underflow = 0.
  - Memory contents are not reset.
- Reset mid-operation discards all stored words immediately. The first accepted write after rst deasserts lands at address 0.
- Write accept: wr_en = write & ~fifo_full.
  - On clk edge: mem[write_ptr] <= data_in, write_ptr increments.
  - A write while full is rejected even if a read occurs the same cycle; overflow = 1 on the next cycle.
- Read accept: rd_en = read & ~fifo_empty.
  - read_ptr increments.
  - A read while empty is rejected even with a simultaneous write; underflow = 1 on the next cycle.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- count update per edge:
  - +1 on wr_en only
  - -1 on rd_en only
  - unchanged on both or neither
- All status flags derive combinationally from the registered count, so they update in the cycle after the causing edge.
- FWFT = 0:
  - On rd_en, data_out <= mem[read_ptr] at the edge; valid the cycle after the read request.
  - data_out holds its last value otherwise, including after a rejected read.
- FWFT = 1:
  - data_out = mem[read_ptr] (asynchronous array read) while fifo_empty = 0.
  - A write into an empty FIFO appears on data_out the cycle after the write edge.
  - rd_en consumes the displayed word; the next word appears after that edge.
  - data_out is don't-care while empty; the bench must not check it.
- Simultaneous write+read when 0 < count < DEPTH: both accepted, count unchanged. In FWFT the head advances.
- Parameter checks in an initial block, each reporting $error:
  - DEPTH not a power of two, or DEPTH < 2.
  - WIDTH < 1.
  - AF_THRESH > DEPTH.
  - AE_THRESH >= DEPTH.

Decomposition:
- Package fifo_pkg: localparam helpers for pointer width ($clog2(DEPTH)) and count width ($clog2(DEPTH+1)); enum fifo_mode_e {FIFO_STD=0, FIFO_FWFT=1}.
- Sub-module fifo_mem:
  - Simple dual-port register array, parameters WIDTH and DEPTH.
  - Synchronous write port; asynchronous read port.
  - Control logic stays in sync_fifo.

Test Plan:
- Reset then idle, WIDTH=8, DEPTH=16 -> count=0, fifo_empty=1, almost_empty=1, fifo_full=0, overflow=underflow=0, data_out=0.
- FWFT=0: write 0x11..0x20 (16 words), then one extra write of 0xFF -> fifo_full=1, count=16, almost_full=1 from count 14, overflow pulses exactly one cycle. Then 16 reads -> data_out sequence 0x11..0x20, each 1 cycle after its read, 0xFF never seen.
- Read on empty with simultaneous write of 0xAB -> underflow pulses one cycle, count=1. In FWFT=1, data_out=0xAB next cycle.
- Fill to 8, then 40 cycles of simultaneous write+read with incrementing data -> count stays 8, output order preserved across pointer wrap, no error pulses.
- FWFT=1: write 0x5A to empty FIFO -> data_out=0x5A the next cycle, before any read. Read -> fifo_empty=1 the following cycle.
- Fill to 10, assert rst asynchronously mid-cycle -> outputs hit reset values without a clock edge. Write 0x33 and read back -> 0x33 (no stale data).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and read-mode encoding for the sync_fifo slice.
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Address width for a DEPTH-entry array; at least one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

    // Occupancy width able to hold 0..DEPTH inclusive.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [ptr_w(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]          wdata,
    input  logic [ptr_w(DEPTH)-1:0]   raddr,
    output logic [WIDTH-1:0]          rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter, threshold flags, error pulses
// and selectable standard / first-word-fall-through read mode.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned FWFT      = 0,
    parameter int unsigned AF_THRESH = DEPTH - 2,
    parameter int unsigned AE_THRESH = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          data_in,
    input  logic                      write,
    input  logic                      read,
    output logic [WIDTH-1:0]          data_out,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      fifo_full,
    output logic                      fifo_empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = cnt_w(DEPTH);
    localparam fifo_mode_e  MODE  = (FWFT != 0) ? FIFO_FWFT : FIFO_STD;

    logic [PTR_W-1:0] write_ptr;
    logic [PTR_W-1:0] read_ptr;
    logic [WIDTH-1:0] rd_data;
    logic             wr_en;
    logic             rd_en;

    // Elaboration-time sanity checks on the parameter set.
    initial begin
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0))
            $error("sync_fifo: DEPTH must be a power of two and >= 2");
        if (WIDTH < 1)
            $error("sync_fifo: WIDTH must be >= 1");
        if (AF_THRESH > DEPTH)
            $error("sync_fifo: AF_THRESH must not exceed DEPTH");
        if (AE_THRESH >= DEPTH)
            $error("sync_fifo: AE_THRESH must be below DEPTH");
    end

    // Requests are gated by the flags of the current cycle; no bypass when full/empty.
    assign wr_en = write & ~fifo_full;
    assign rd_en = read  & ~fifo_empty;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (write_ptr),
        .wdata (data_in),
        .raddr (read_ptr),
        .rdata (rd_data)
    );

    // Pointers, occupancy and registered error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_ptr <= '0;
            read_ptr  <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) write_ptr <= write_ptr + PTR_W'(1);
            if (rd_en) read_ptr  <= read_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            overflow  <= write & fifo_full;
            underflow <= read & fifo_empty;
        end
    end

    // Status flags follow the registered occupancy.
    assign fifo_full    = (count == CNT_W'(DEPTH));
    assign fifo_empty   = (count == CNT_W'(0));
    assign almost_full  = (count >= CNT_W'(AF_THRESH));
    assign almost_empty = (count <= CNT_W'(AE_THRESH));

    generate
        if (MODE == FIFO_FWFT) begin : g_fwft
            // Head word shown directly; forced to zero while empty so reset reads 0.
            assign data_out = fifo_empty ? '0 : rd_data;
        end else begin : g_std
            // Registered output captured only on an accepted read.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_out <= '0;
                end else if (rd_en) begin
                    data_out <= rd_data;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: a standard and an FWFT instance share one stimulus stream.
module tb_sync_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       write = 1'b0;
    logic       read = 1'b0;

    logic [7:0] dout_s, dout_f;
    logic [4:0] cnt_s, cnt_f;
    logic       full_s, empty_s, afull_s, aempty_s, ovf_s, unf_s;
    logic       full_f, empty_f, afull_f, aempty_f, ovf_f, unf_f;
    logic [5:0] flags_s, flags_f;

    int total = 0;
    int bad = 0;

    // flags = {full, almost_full, empty, almost_empty, overflow, underflow}
    assign flags_s = {full_s, afull_s, empty_s, aempty_s, ovf_s, unf_s};
    assign flags_f = {full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f};

    always #5 clk = ~clk;

    sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
        .clk(clk), .rst(rst), .data_in(data_in), .write(write), .read(read),
        .data_out(dout_s), .count(cnt_s), .fifo_full(full_s), .fifo_empty(empty_s),
        .almost_full(afull_s), .almost_empty(aempty_s),
        .overflow(ovf_s), .underflow(unf_s)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fwft (
        .clk(clk), .rst(rst), .data_in(data_in), .write(write), .read(read),
        .data_out(dout_f), .count(cnt_f), .fifo_full(full_f), .fifo_empty(empty_f),
        .almost_full(afull_f), .almost_empty(aempty_f),
        .overflow(ovf_f), .underflow(unf_f)
    );

    // Apply one cycle of requests, leave the bench 1 time unit after the edge.
    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        write = w;
        read = r;
        data_in = d;
        @(posedge clk);
        #1;
        write = 1'b0;
        read = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #12;
        total++;
        if (flags_s !== 6'b001100) begin
            bad++; $display("FAIL reset_flags_std got=%b want=001100", flags_s);
        end
        total++;
        if (cnt_s !== 5'd0 || cnt_f !== 5'd0) begin
            bad++; $display("FAIL reset_count got=%0d/%0d want=0", cnt_s, cnt_f);
        end
        total++;
        if (dout_s !== 8'h00) begin
            bad++; $display("FAIL reset_data_out got=%h want=00", dout_s);
        end
        rst = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);
        total++;
        if (flags_s !== 6'b001100 || flags_f !== 6'b001100) begin
            bad++; $display("FAIL idle_flags got=%b/%b want=001100", flags_s, flags_f);
        end
    endtask

    task automatic test_fill_drain();
        logic [5:0] exp_flags;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 1'b0, 8'(32'h11 + i));
            exp_flags = {(i + 1) == 16, (i + 1) >= 14, 1'b0, (i + 1) <= 2, 1'b0, 1'b0};
            total++;
            if (cnt_s !== 5'(i + 1) || flags_s !== exp_flags || flags_f !== exp_flags) begin
                bad++;
                $display("FAIL fill_%0d got cnt=%0d flags=%b/%b want cnt=%0d flags=%b",
                         i, cnt_s, flags_s, flags_f, i + 1, exp_flags);
            end
        end
        cyc(1'b1, 1'b0, 8'hFF);
        total++;
        if (cnt_s !== 5'd16 || flags_s !== 6'b110010 || flags_f !== 6'b110010) begin
            bad++;
            $display("FAIL overflow_pulse got cnt=%0d flags=%b/%b want cnt=16 flags=110010",
                     cnt_s, flags_s, flags_f);
        end
        cyc(1'b0, 1'b0, 8'h00);
        total++;
        if (ovf_s !== 1'b0 || ovf_f !== 1'b0 || cnt_s !== 5'd16) begin
            bad++; $display("FAIL overflow_one_cycle got ovf=%b/%b cnt=%0d want 0/0 16",
                            ovf_s, ovf_f, cnt_s);
        end
        for (int i = 0; i < 16; i++) begin
            total++;
            if (dout_f !== 8'(32'h11 + i)) begin
                bad++; $display("FAIL fwft_head_%0d got=%h want=%h", i, dout_f, 8'(32'h11 + i));
            end
            cyc(1'b0, 1'b1, 8'h00);
            total++;
            if (dout_s !== 8'(32'h11 + i) || cnt_s !== 5'(15 - i)) begin
                bad++;
                $display("FAIL drain_%0d got data=%h cnt=%0d want data=%h cnt=%0d",
                         i, dout_s, cnt_s, 8'(32'h11 + i), 15 - i);
            end
        end
        total++;
        if (flags_s !== 6'b001100) begin
            bad++; $display("FAIL drained_flags got=%b want=001100", flags_s);
        end
    endtask

    task automatic test_underflow();
        cyc(1'b1, 1'b1, 8'hAB);
        total++;
        if (unf_s !== 1'b1 || unf_f !== 1'b1 || cnt_s !== 5'd1 || cnt_f !== 5'd1) begin
            bad++; $display("FAIL underflow_pulse got unf=%b/%b cnt=%0d/%0d want 1/1 1/1",
                            unf_s, unf_f, cnt_s, cnt_f);
        end
        total++;
        if (dout_f !== 8'hAB || dout_s !== 8'h20) begin
            bad++; $display("FAIL underflow_data got fwft=%h std=%h want AB 20", dout_f, dout_s);
        end
        cyc(1'b0, 1'b0, 8'h00);
        total++;
        if (unf_s !== 1'b0 || unf_f !== 1'b0) begin
            bad++; $display("FAIL underflow_one_cycle got=%b/%b want 0", unf_s, unf_f);
        end
        cyc(1'b0, 1'b1, 8'h00);
        total++;
        if (dout_s !== 8'hAB || empty_s !== 1'b1) begin
            bad++; $display("FAIL readback_ab got data=%h empty=%b want AB 1", dout_s, empty_s);
        end
        cyc(1'b0, 1'b1, 8'h00);
        total++;
        if (unf_s !== 1'b1 || dout_s !== 8'hAB || cnt_s !== 5'd0) begin
            bad++; $display("FAIL empty_read_hold got unf=%b data=%h cnt=%0d want 1 AB 0",
                            unf_s, dout_s, cnt_s);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 8'(32'h40 + k));
        total++;
        if (cnt_s !== 5'd8 || cnt_f !== 5'd8) begin
            bad++; $display("FAIL b2b_prefill got=%0d/%0d want=8", cnt_s, cnt_f);
        end
        for (int k = 0; k < 40; k++) begin
            total++;
            if (dout_f !== 8'(32'h40 + k)) begin
                bad++; $display("FAIL b2b_fwft_%0d got=%h want=%h", k, dout_f, 8'(32'h40 + k));
            end
            cyc(1'b1, 1'b1, 8'(32'h48 + k));
            total++;
            if (dout_s !== 8'(32'h40 + k) || cnt_s !== 5'd8 || cnt_f !== 5'd8 ||
                {ovf_s, unf_s, ovf_f, unf_f} !== 4'b0000) begin
                bad++;
                $display("FAIL b2b_%0d got data=%h cnt=%0d err=%b want data=%h cnt=8 err=0000",
                         k, dout_s, cnt_s, {ovf_s, unf_s, ovf_f, unf_f}, 8'(32'h40 + k));
            end
        end
        for (int k = 40; k < 48; k++) begin
            cyc(1'b0, 1'b1, 8'h00);
            total++;
            if (dout_s !== 8'(32'h40 + k)) begin
                bad++; $display("FAIL b2b_drain_%0d got=%h want=%h", k, dout_s, 8'(32'h40 + k));
            end
        end
        total++;
        if (empty_s !== 1'b1 || empty_f !== 1'b1) begin
            bad++; $display("FAIL b2b_empty got=%b/%b want=1", empty_s, empty_f);
        end
    endtask

    task automatic test_fall_through();
        cyc(1'b1, 1'b0, 8'h5A);
        total++;
        if (dout_f !== 8'h5A || empty_f !== 1'b0 || cnt_f !== 5'd1) begin
            bad++; $display("FAIL fwft_5a got data=%h empty=%b cnt=%0d want 5A 0 1",
                            dout_f, empty_f, cnt_f);
        end
        cyc(1'b0, 1'b1, 8'h00);
        total++;
        if (empty_f !== 1'b1 || dout_s !== 8'h5A) begin
            bad++; $display("FAIL fwft_consume got empty=%b std_data=%h want 1 5A",
                            empty_f, dout_s);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 8'(32'h60 + k));
        total++;
        if (cnt_s !== 5'd10) begin
            bad++; $display("FAIL prefill_10 got=%0d want=10", cnt_s);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (cnt_s !== 5'd0 || cnt_f !== 5'd0 || flags_s !== 6'b001100 ||
            flags_f !== 6'b001100 || dout_s !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got cnt=%0d/%0d flags=%b/%b data=%h want 0/0 001100 00",
                     cnt_s, cnt_f, flags_s, flags_f, dout_s);
        end
        #3;
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'h33);
        total++;
        if (cnt_s !== 5'd1 || dout_f !== 8'h33) begin
            bad++; $display("FAIL post_reset_write got cnt=%0d fwft=%h want 1 33", cnt_s, dout_f);
        end
        cyc(1'b0, 1'b1, 8'h00);
        total++;
        if (dout_s !== 8'h33 || empty_s !== 1'b1) begin
            bad++; $display("FAIL post_reset_read got data=%h empty=%b want 33 1", dout_s, empty_s);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_underflow();
        test_back_to_back();
        test_fall_through();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
